// File: rtl/bcd_pkg.sv
// Shared types and constants for the two-digit BCD adder.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SUM_W   = DIGIT_W + 1;
  localparam int unsigned CORR_W  = DIGIT_W + 2;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_adder_digit_add.sv
// Combinational single-digit BCD add with decimal correction.
// Optional invalid-digit output is present when BCD_ERR_EN is defined.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum_c,
  output logic       cout_c
`ifdef BCD_ERR_EN
  , output logic     invalid_c
`endif
);

  logic [SUM_W-1:0] s;

  // Out-of-range digits go through the same correction; the 6-bit add covers s = 31.
  always_comb begin
    s      = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
    sum_c  = DIGIT_W'(s);
    cout_c = 1'b0;
    if (s > SUM_W'(BCD_MAX)) begin
      sum_c  = DIGIT_W'(CORR_W'(s) + CORR_W'(BCD_CORR));
      cout_c = 1'b1;
    end
  end

`ifdef BCD_ERR_EN
  assign invalid_c = (a > BCD_MAX) || (b > BCD_MAX);
`endif

endmodule

// File: rtl/bcd_adder.sv
// Registered two-digit packed-BCD adder (000-198), one-cycle latency.
// Define BCD_ERR_EN to add the registered invalid-digit flag err.
module bcd_adder
  import bcd_pkg::*;
(
  output logic [3:0] Cout,
  output logic [3:0] Ymsd,
  output logic [3:0] Ylsd,
  input  logic [3:0] Amsd,
  input  logic [3:0] Alsd,
  input  logic [3:0] Bmsd,
  input  logic [3:0] Blsd,
  input  logic       clk,
  input  logic       rst
`ifdef BCD_ERR_EN
  , output logic     err
`endif
);

  bcd_digit_t lsd_sum_c;
  bcd_digit_t msd_sum_c;
  logic       c0_c;
  logic       c1_c;

`ifdef BCD_ERR_EN
  logic       lsd_inv_c;
  logic       msd_inv_c;
`endif

  bcd_digit_add u_lsd (
    .a        (Alsd),
    .b        (Blsd),
    .cin      (1'b0),
    .sum_c    (lsd_sum_c),
    .cout_c   (c0_c)
`ifdef BCD_ERR_EN
    , .invalid_c(lsd_inv_c)
`endif
  );

  bcd_digit_add u_msd (
    .a        (Amsd),
    .b        (Bmsd),
    .cin      (c0_c),
    .sum_c    (msd_sum_c),
    .cout_c   (c1_c)
`ifdef BCD_ERR_EN
    , .invalid_c(msd_inv_c)
`endif
  );

  // Reset wins over the sum sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      Cout <= '0;
      Ymsd <= '0;
      Ylsd <= '0;
    end else begin
      Cout <= {3'b000, c1_c};
      Ymsd <= msd_sum_c;
      Ylsd <= lsd_sum_c;
    end
  end

`ifdef BCD_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= lsd_inv_c | msd_inv_c;
  end
`endif

endmodule

// File: tb/tb_bcd_adder.sv
// Self-checking bench for bcd_adder: directed cases plus random operands
// compared against a decimal-arithmetic reference model.
module tb_bcd_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Cout, Ymsd, Ylsd;
  logic [3:0] Amsd, Alsd, Bmsd, Blsd;
`ifdef BCD_ERR_EN
  logic       err;
`endif

  int errors = 0;
  int checks = 0;

  bcd_adder dut (
    .Cout (Cout),
    .Ymsd (Ymsd),
    .Ylsd (Ylsd),
    .Amsd (Amsd),
    .Alsd (Alsd),
    .Bmsd (Bmsd),
    .Blsd (Blsd),
    .clk  (clk),
    .rst  (rst)
`ifdef BCD_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive operands, clock once, and compare against the reference model.
  task automatic step(input int am, input int al, input int bm, input int bl,
                      input logic r, input string tag);
    int  total, s, cy, c, y1, y0;
    bit  valid;
    Amsd = 4'(am); Alsd = 4'(al); Bmsd = 4'(bm); Blsd = 4'(bl);
    rst  = r;
    valid = (am <= 9) && (al <= 9) && (bm <= 9) && (bl <= 9);
    if (r) begin
      c = 0; y1 = 0; y0 = 0;
    end else if (valid) begin
      total = (am * 10 + al) + (bm * 10 + bl);
      c  = total / 100;
      y1 = (total / 10) % 10;
      y0 = total % 10;
    end else begin
      s  = al + bl;
      cy = (s > 9) ? 1 : 0;
      y0 = (s > 9) ? (s + 6) % 16 : s;
      s  = am + bm + cy;
      c  = (s > 9) ? 1 : 0;
      y1 = (s > 9) ? (s + 6) % 16 : s;
    end
    @(posedge clk);
    #1;
    chk({tag, ".cout"}, Cout, 4'(c));
    chk({tag, ".ymsd"}, Ymsd, 4'(y1));
    chk({tag, ".ylsd"}, Ylsd, 4'(y0));
`ifdef BCD_ERR_EN
    chk({tag, ".err"}, {3'b000, err}, {3'b000, (!r && !valid)});
`endif
  endtask

  initial begin
    rst = 1'b1;
    Amsd = '0; Alsd = '0; Bmsd = '0; Blsd = '0;

    step($urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 0), 1'b1, "reset0");
    step($urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 0), 1'b1, "reset1");

    step(4, 6, 8, 9, 1'b0, "46p89");
    step(5, 6, 7, 2, 1'b0, "56p72");
    step(3, 5, 2, 8, 1'b0, "35p28");
    step(5, 6, 2, 1, 1'b0, "56p21");
    step(9, 9, 9, 9, 1'b0, "99p99");
    step(0, 0, 0, 0, 1'b0, "00p00");

    step(9, 9, 9, 9, 1'b1, "midrst");
    step(9, 9, 9, 9, 1'b0, "postrst");

    step(0, 10, 0, 0, 1'b0, "lsdA");
    step(15, 15, 0, 1, 1'b0, "ff_p01");
    step(1, 2, 3, 4, 1'b0, "validafter");

    for (int i = 0; i < 40; i++)
      step($urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 0), 1'b0, "rnd");

    for (int i = 0; i < 12; i++)
      step($urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0), 1'b0, "rndraw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
